// File: rtl/alu_mux_sel_ctrl_pkg.sv
// Shared types and constants for the ALU result-mux select controller:
// op encodings, one-hot mux selects, FSM states and the captured response.
package alu_mux_sel_ctrl_pkg;

   typedef enum logic [1:0] {
      OpAdd = 2'b00,
      OpAnd = 2'b01,
      OpOr  = 2'b10,
      OpXor = 2'b11
   } alu_op_e;

   // Mux input a..d maps to sel[3]..sel[0].
   localparam logic [3:0] SEL_ADD  = 4'b1000;
   localparam logic [3:0] SEL_AND  = 4'b0100;
   localparam logic [3:0] SEL_OR   = 4'b0010;
   localparam logic [3:0] SEL_XOR  = 4'b0001;
   localparam logic [3:0] SEL_NONE = 4'b0000;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StDrive = 2'd1,
      StResp  = 2'd2
   } state_e;

   // Wide enough for settle windows 1..15.
   localparam int unsigned SETTLE_W = 4;

   typedef struct packed {
      logic [7:0] result;
      logic       zero;
      logic       carry;
   } resp_t;

   // Carry is only meaningful for the adder path; other ops report 0.
   function automatic resp_t capture_resp(alu_op_e op, logic [7:0] y, logic cout);
      resp_t r;
      r.result = y;
      r.zero   = (y == 8'h00);
      r.carry  = (op == OpAdd) ? cout : 1'b0;
      return r;
   endfunction

endpackage

// File: rtl/alu_mux_sel_ctrl_if.sv
// Request, ALU datapath and response signals of the select controller.
// slave is the controller's view; master is the requester/datapath/consumer side.
interface alu_mux_sel_ctrl_if #(
   parameter int unsigned CNT_W = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [1:0]       in_op;
   logic [7:0]       in_a;
   logic [7:0]       in_b;

   logic [7:0]       alu_a;
   logic [7:0]       alu_b;
   logic [3:0]       alu_sel;
   logic [7:0]       alu_y;
   logic             alu_cout;

   logic             out_valid;
   logic             out_ready;
   logic [7:0]       out_result;
   logic             out_zero;
   logic             out_carry;
   logic [CNT_W-1:0] op_count;

   modport slave (
      input  in_valid, in_op, in_a, in_b, alu_y, alu_cout, out_ready,
      output in_ready, alu_a, alu_b, alu_sel, out_valid, out_result, out_zero, out_carry,
             op_count
   );

   modport master (
      output in_valid, in_op, in_a, in_b, alu_y, alu_cout, out_ready,
      input  in_ready, alu_a, alu_b, alu_sel, out_valid, out_result, out_zero, out_carry,
             op_count
   );

endinterface

// File: rtl/alu_sel_decode.sv
// Combinational 2-bit op to one-hot 4-bit mux select decoder.
// When disabled the select is all-zero so no mux input is driven.
module alu_sel_decode
   import alu_mux_sel_ctrl_pkg::*;
(
   input  logic       en,
   input  alu_op_e    op,
   output logic [3:0] sel
);

   always_comb begin
      sel = SEL_NONE;
      if (en) begin
         unique case (op)
            OpAdd: sel = SEL_ADD;
            OpAnd: sel = SEL_AND;
            OpOr:  sel = SEL_OR;
            OpXor: sel = SEL_XOR;
         endcase
      end
   end

endmodule

// File: rtl/alu_mux_sel_ctrl.sv
// Control stage ahead of the 8-bit ALU result mux: accepts one op, holds operands and
// a one-hot select for SETTLE_CYCLES cycles, then captures and presents the muxed result.
module alu_mux_sel_ctrl
   import alu_mux_sel_ctrl_pkg::*;
#(
   parameter int unsigned SETTLE_CYCLES = 1,
   parameter int unsigned CNT_W         = 16
) (
   input logic               clk,
   input logic               rst,
   alu_mux_sel_ctrl_if.slave bus
);

   localparam logic [SETTLE_W-1:0] SettleLoad = SETTLE_W'(SETTLE_CYCLES - 1);

   state_e              state_q;
   logic                in_ready_q;
   logic [7:0]          a_q;
   logic [7:0]          b_q;
   alu_op_e             op_q;
   logic [3:0]          sel_q;
   logic [SETTLE_W-1:0] settle_q;
   logic                out_valid_q;
   resp_t               resp_q;
   logic [CNT_W-1:0]    count_q;

   alu_op_e             req_op;
   logic                accept;
   logic [3:0]          dec_sel;

   assign req_op = alu_op_e'(bus.in_op);
   assign accept = bus.in_valid & in_ready_q;

   // Decoded on the accept cycle so alu_sel leaves a register together with the operands.
   alu_sel_decode u_sel_decode (
      .en  (accept),
      .op  (req_op),
      .sel (dec_sel)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         in_ready_q  <= 1'b1;
         a_q         <= 8'h00;
         b_q         <= 8'h00;
         op_q        <= OpAdd;
         sel_q       <= SEL_NONE;
         settle_q    <= '0;
         out_valid_q <= 1'b0;
         resp_q      <= '0;
         count_q     <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (accept) begin
                  a_q        <= bus.in_a;
                  b_q        <= bus.in_b;
                  op_q       <= req_op;
                  sel_q      <= dec_sel;
                  settle_q   <= SettleLoad;
                  in_ready_q <= 1'b0;
                  state_q    <= StDrive;
               end
            end
            StDrive: begin
               if (settle_q == '0) begin
                  resp_q      <= capture_resp(op_q, bus.alu_y, bus.alu_cout);
                  out_valid_q <= 1'b1;
                  sel_q       <= SEL_NONE;
                  state_q     <= StResp;
               end else begin
                  settle_q <= settle_q - SETTLE_W'(1);
               end
            end
            StResp: begin
               // in_ready stays low this cycle, so a new request can only land from idle.
               if (bus.out_ready) begin
                  out_valid_q <= 1'b0;
                  count_q     <= count_q + CNT_W'(1);
                  in_ready_q  <= 1'b1;
                  state_q     <= StIdle;
               end
            end
            default: begin
               sel_q      <= SEL_NONE;
               in_ready_q <= 1'b1;
               state_q    <= StIdle;
            end
         endcase
      end
   end

   assign bus.in_ready   = in_ready_q;
   assign bus.alu_a      = a_q;
   assign bus.alu_b      = b_q;
   assign bus.alu_sel    = sel_q;
   assign bus.out_valid  = out_valid_q;
   assign bus.out_result = resp_q.result;
   assign bus.out_zero   = resp_q.zero;
   assign bus.out_carry  = resp_q.carry;
   assign bus.op_count   = count_q;

endmodule
